// File: rtl/axil_crossbar_wr.sv
// AXI-Lite write crossbar stage: N masters share one slave port for AW/W/B.
// One write transaction owns the port from grant until its B handshake completes.
module axil_crossbar_wr #(
  parameter int NUMBER_MASTER  = 2,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  output logic [NUMBER_MASTER-1:0]                  grant_wr,
  input  logic [NUMBER_MASTER*AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  input  logic [NUMBER_MASTER-1:0]                  m_axil_awvalid,
  output logic [NUMBER_MASTER-1:0]                  m_axil_awready,
  input  logic [NUMBER_MASTER*AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  input  logic [NUMBER_MASTER*AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  input  logic [NUMBER_MASTER-1:0]                  m_axil_wvalid,
  output logic [NUMBER_MASTER-1:0]                  m_axil_wready,
  output logic [NUMBER_MASTER*2-1:0]                m_axil_bresp,
  output logic [NUMBER_MASTER-1:0]                  m_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0]                  m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]                 s_axil_awaddr,
  output logic                                      s_axil_awvalid,
  input  logic                                      s_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]                 s_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]               s_axil_wstrb,
  output logic                                      s_axil_wvalid,
  input  logic                                      s_axil_wready,
  input  logic [1:0]                                s_axil_bresp,
  input  logic                                      s_axil_bvalid,
  output logic                                      s_axil_bready
);

  // state | meaning
  // IDLE  | no owner; arbitrate among requesters, nothing forwarded
  // XFER  | owner's AW and W routed to slave until both have handshaken
  // RESP  | slave B routed back to owner until B handshake

  localparam int N  = NUMBER_MASTER;
  localparam int IW = $clog2(NUMBER_MASTER);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t          state;
  logic            aw_done;
  logic            w_done;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;

  logic [N-1:0]    req;
  logic [IW-1:0]   hi_idx;
  logic [IW-1:0]   lo_idx;
  logic            hi_vld;
  logic            lo_vld;
  logic [IW-1:0]   pick;
  logic            pick_vld;

  logic [AW-1:0]   sel_awaddr;
  logic            sel_awvalid;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_wstrb;
  logic            sel_wvalid;
  logic            sel_bready;

  logic            in_xfer;
  logic            in_resp;
  logic            aw_fire;
  logic            w_fire;
  logic            b_fire;

  assign req = m_axil_awvalid | m_axil_wvalid;

  // Round robin: lowest requester above rr_ptr wins, else wrap to the lowest overall.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IW'(i) > rr_ptr) begin
          hi_vld = 1'b1;
          hi_idx = IW'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = IW'(i);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick     = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_awaddr  = '0;
    sel_awvalid = 1'b0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_wr[i]) begin
        sel_awaddr  = sel_awaddr | m_axil_awaddr[i*AW +: AW];
        sel_awvalid = sel_awvalid | m_axil_awvalid[i];
        sel_wdata   = sel_wdata | m_axil_wdata[i*DW +: DW];
        sel_wstrb   = sel_wstrb | m_axil_wstrb[i*SW +: SW];
        sel_wvalid  = sel_wvalid | m_axil_wvalid[i];
        sel_bready  = sel_bready | m_axil_bready[i];
      end
    end
  end

  assign in_xfer = (state == XFER);
  assign in_resp = (state == RESP);

  assign s_axil_awvalid = in_xfer & sel_awvalid & ~aw_done;
  assign s_axil_awaddr  = in_xfer ? sel_awaddr : '0;
  assign s_axil_wvalid  = in_xfer & sel_wvalid & ~w_done;
  assign s_axil_wdata   = in_xfer ? sel_wdata : '0;
  assign s_axil_wstrb   = in_xfer ? sel_wstrb : '0;
  assign s_axil_bready  = in_resp & sel_bready;

  assign m_axil_awready = grant_wr & {N{in_xfer & s_axil_awready & ~aw_done}};
  assign m_axil_wready  = grant_wr & {N{in_xfer & s_axil_wready & ~w_done}};
  assign m_axil_bvalid  = grant_wr & {N{in_resp & s_axil_bvalid}};

  always_comb begin
    m_axil_bresp = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_wr[i] && in_resp) m_axil_bresp[i*2 +: 2] = s_axil_bresp;
    end
  end

  assign aw_fire = s_axil_awvalid & s_axil_awready;
  assign w_fire  = s_axil_wvalid & s_axil_wready;
  assign b_fire  = s_axil_bvalid & s_axil_bready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      grant_wr <= '0;
      owner    <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rr_ptr   <= IW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= XFER;
            owner    <= pick;
            grant_wr <= {{(N-1){1'b0}}, 1'b1} << pick;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        XFER: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
          if ((aw_done | aw_fire) & (w_done | w_fire)) state <= RESP;
        end
        RESP: begin
          if (b_fire) begin
            state    <= IDLE;
            grant_wr <= '0;
            rr_ptr   <= owner;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
